// File: rtl/jump_pkg.sv
// rtl/jump_pkg.sv - thread and address definitions shared by the jump stack and its resolve end
package jump_pkg;
   localparam int NUM_THREADS        = 4;
   localparam int ADDR_WIDTH_DEFAULT = 22;

   typedef logic [1:0] thread_t;
endpackage

// File: rtl/jump_resolve_queue.sv
// rtl/jump_resolve_queue.sv - single-thread FIFO of in-flight jr target predictions
module jump_resolve_queue #(
   parameter int ADDRESS_WIDTH = 22,
   parameter int QUEUE_DEPTH   = 4
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset_n,
   input  logic                     i_enq,
   input  logic [ADDRESS_WIDTH-1:0] i_enq_data,
   input  logic                     i_deq,
   input  logic                     i_clear,
   output logic [ADDRESS_WIDTH-1:0] o_head,
   output logic                     o_empty,
   output logic                     o_full
);
   localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [ADDRESS_WIDTH-1:0] r_mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]         r_rd_ptr;
   logic [PTR_W-1:0]         r_wr_ptr;
   logic [CNT_W-1:0]         r_count;
   logic                     w_do_enq;
   logic                     w_do_deq;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == CNT_W'(QUEUE_DEPTH));
   assign w_do_deq = i_deq && !o_empty;
   // A full queue still accepts when its head leaves in the same cycle
   assign w_do_enq = i_enq && (!o_full || w_do_deq);
   assign o_head   = r_mem[r_rd_ptr];

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_enq, w_do_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (w_do_enq && !i_clear) r_mem[r_wr_ptr] <= i_enq_data;
   end
endmodule

// File: rtl/jump_resolve.sv
// rtl/jump_resolve.sv - resolves jr predictions against execute targets; redirects fetch on a miss
module jump_resolve
   import jump_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int QUEUE_DEPTH   = 4,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset_n,
   input  logic                     i_Stall,
   input  logic                     i_pred_valid,
   input  logic [1:0]               i_pred_thread,
   input  logic [ADDRESS_WIDTH-1:0] i_pred_address,
   input  logic                     i_res_valid,
   input  logic [1:0]               i_res_thread,
   input  logic [ADDRESS_WIDTH-1:0] i_res_address,
   input  logic                     i_flush_valid,
   input  logic [1:0]               i_flush_thread,
   output logic [3:0]               o_full,
   output logic                     o_redirect_valid,
   output logic [1:0]               o_redirect_thread,
   output logic [ADDRESS_WIDTH-1:0] o_redirect_address,
   output logic                     o_hit,
   output logic                     o_overflow,
   output logic [COUNT_WIDTH-1:0]   o_mispredict_count
);
   logic [ADDRESS_WIDTH-1:0] w_head [NUM_THREADS];
   logic [NUM_THREADS-1:0]   w_empty;
   logic [NUM_THREADS-1:0]   w_full;
   logic [NUM_THREADS-1:0]   w_enq;
   logic [NUM_THREADS-1:0]   w_deq;
   logic [NUM_THREADS-1:0]   w_clear;
   logic                     w_res_act;
   logic                     w_hit;
   logic                     w_miss;
   logic                     w_overflow;

   logic                     r_redirect_valid;
   thread_t                  r_redirect_thread;
   logic [ADDRESS_WIDTH-1:0] r_redirect_address;
   logic                     r_hit;
   logic                     r_overflow;
   logic [COUNT_WIDTH-1:0]   r_mispredict_count;

   // A flush of the resolving thread swallows the resolve entirely
   assign w_res_act = i_res_valid && !i_Stall &&
                      !(i_flush_valid && (i_flush_thread == i_res_thread));
   assign w_hit     = w_res_act && !w_empty[i_res_thread] &&
                      (w_head[i_res_thread] == i_res_address);
   assign w_miss    = w_res_act && !w_hit;

   always_comb begin
      w_enq   = '0;
      w_deq   = '0;
      w_clear = '0;
      if (!i_Stall) begin
         w_enq[i_pred_thread] = i_pred_valid;
         w_deq[i_res_thread]  = w_hit;
         w_clear[i_res_thread] = w_miss;
         if (i_flush_valid) w_clear[i_flush_thread] = 1'b1;
      end
   end

   assign w_overflow = |(w_enq & w_full & ~w_deq);

   for (genvar g = 0; g < NUM_THREADS; g++) begin : g_queue
      jump_resolve_queue #(
         .ADDRESS_WIDTH (ADDRESS_WIDTH),
         .QUEUE_DEPTH   (QUEUE_DEPTH)
      ) u_queue (
         .i_Clk      (i_Clk),
         .i_Reset_n  (i_Reset_n),
         .i_enq      (w_enq[g]),
         .i_enq_data (i_pred_address),
         .i_deq      (w_deq[g]),
         .i_clear    (w_clear[g]),
         .o_head     (w_head[g]),
         .o_empty    (w_empty[g]),
         .o_full     (w_full[g])
      );
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         r_redirect_valid   <= 1'b0;
         r_redirect_thread  <= '0;
         r_redirect_address <= '0;
         r_hit              <= 1'b0;
         r_overflow         <= 1'b0;
         r_mispredict_count <= '0;
      end else begin
         r_redirect_valid <= w_miss;
         r_hit            <= w_hit;
         if (w_miss) begin
            r_redirect_thread  <= i_res_thread;
            r_redirect_address <= i_res_address;
            if (r_mispredict_count != '1) r_mispredict_count <= r_mispredict_count + 1'b1;
         end
         if (w_overflow) r_overflow <= 1'b1;
      end
   end

   assign o_full             = w_full;
   assign o_redirect_valid   = r_redirect_valid;
   assign o_redirect_thread  = r_redirect_thread;
   assign o_redirect_address = r_redirect_address;
   assign o_hit              = r_hit;
   assign o_overflow         = r_overflow;
   assign o_mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_jump_resolve.sv
// tb/tb_jump_resolve.sv - scoreboard bench for jump_resolve with a queue-based reference model
module tb_jump_resolve;
   localparam int AW = 22;
   localparam int QD = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          stall;
   logic          pred_valid, res_valid, flush_valid;
   logic [1:0]    pred_thread, res_thread, flush_thread;
   logic [AW-1:0] pred_address, res_address;
   logic [3:0]    full;
   logic          redirect_valid, hit, overflow;
   logic [1:0]    redirect_thread;
   logic [AW-1:0] redirect_address;
   logic [CW-1:0] mispredict_count;

   always #5 clk = ~clk;

   jump_resolve #(.ADDRESS_WIDTH(AW), .QUEUE_DEPTH(QD), .COUNT_WIDTH(CW)) dut (
      .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall),
      .i_pred_valid(pred_valid), .i_pred_thread(pred_thread), .i_pred_address(pred_address),
      .i_res_valid(res_valid), .i_res_thread(res_thread), .i_res_address(res_address),
      .i_flush_valid(flush_valid), .i_flush_thread(flush_thread),
      .o_full(full), .o_redirect_valid(redirect_valid), .o_redirect_thread(redirect_thread),
      .o_redirect_address(redirect_address), .o_hit(hit), .o_overflow(overflow),
      .o_mispredict_count(mispredict_count));

   typedef struct {
      int            cyc;
      bit            is_hit;
      logic [1:0]    thr;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t          sb[$];
   logic [AW-1:0] mq [4][$];
   bit            m_ovf;
   int            m_cnt;
   int            cyc   = 0;
   int            tests = 0;
   int            fails = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_step(bit pv, logic [1:0] pt, logic [AW-1:0] pa,
                             bit rv, logic [1:0] rt, logic [AW-1:0] ra,
                             bit fv, logic [1:0] ft);
      bit   res_act, m_hit, m_miss;
      exp_t e;
      res_act = rv && !(fv && ft == rt);
      m_hit   = res_act && mq[rt].size() > 0 && mq[rt][0] == ra;
      m_miss  = res_act && !m_hit;
      if (pv && mq[pt].size() == QD && !(m_hit && rt == pt)) m_ovf = 1'b1;
      if (m_hit) void'(mq[rt].pop_front());
      if (pv && mq[pt].size() < QD && !(fv && ft == pt) && !(m_miss && rt == pt))
         mq[pt].push_back(pa);
      if (m_miss) begin
         mq[rt].delete();
         if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (fv) mq[ft].delete();
      if (res_act) begin
         e.cyc = cyc + 1; e.is_hit = m_hit; e.thr = rt; e.addr = ra;
         sb.push_back(e);
      end
   endtask

   task automatic check_state();
      logic [3:0] exp_full;
      for (int t = 0; t < 4; t++) exp_full[t] = (mq[t].size() == QD);
      chk("full", full, exp_full);
      chk("overflow", overflow, m_ovf);
      chk("mispredict_count", mispredict_count, m_cnt);
   endtask

   task automatic step(bit pv, logic [1:0] pt, logic [AW-1:0] pa,
                       bit rv, logic [1:0] rt, logic [AW-1:0] ra,
                       bit fv, logic [1:0] ft, bit st);
      pred_valid = pv; pred_thread = pt; pred_address = pa;
      res_valid = rv; res_thread = rt; res_address = ra;
      flush_valid = fv; flush_thread = ft; stall = st;
      if (!st) model_step(pv, pt, pa, rv, rt, ra, fv, ft);
      @(negedge clk);
      check_state();
   endtask

   task automatic idle();
      step(0, 0, '0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic enq(logic [1:0] t, logic [AW-1:0] a);
      step(1, t, a, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic res(logic [1:0] t, logic [AW-1:0] a);
      step(0, 0, '0, 1, t, a, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (redirect_valid || hit) begin
            if (sb.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_pulse: got hit=%0b redirect=%0b expected none (cycle %0d)",
                        hit, redirect_valid, cyc);
            end else begin
               e = sb.pop_front();
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_hit", hit, e.is_hit);
               chk("pulse_redirect", redirect_valid, !e.is_hit);
               if (!e.is_hit) begin
                  chk("redirect_thread", redirect_thread, e.thr);
                  chk("redirect_address", redirect_address, e.addr);
               end
            end
         end
      end
   end

   initial begin : stimulus
      logic [1:0]    t, r;
      logic [AW-1:0] a;
      rst_n = 1'b0;
      stall = 0; pred_valid = 0; res_valid = 0; flush_valid = 0;
      pred_thread = 0; res_thread = 0; flush_thread = 0;
      pred_address = '0; res_address = '0;
      m_ovf = 0; m_cnt = 0;
      repeat (2) @(negedge clk);
      check_state();
      chk("reset_redirect_valid", redirect_valid, 0);
      chk("reset_redirect_thread", redirect_thread, 0);
      chk("reset_redirect_address", redirect_address, 0);
      chk("reset_hit", hit, 0);
      rst_n = 1'b1;

      enq(0, 22'h000100); res(0, 22'h000100); idle();
      enq(1, 22'h000200); enq(1, 22'h000300); res(1, 22'h000204); res(1, 22'h000300); idle();
      res(2, 22'h0000AA);
      step(1, 2, 22'h0000AA, 1, 2, 22'h0000AA, 0, 0, 0); idle();
      for (int i = 0; i < 5; i++) enq(3, 22'h003000 + AW'(i));
      chk("full_t3_after_overflow", full[3], 1);
      chk("overflow_set", overflow, 1);
      for (int i = 0; i < 4; i++) res(3, 22'h003000 + AW'(i));
      idle();
      chk("overflow_sticky", overflow, 1);
      enq(0, 22'h000010);
      step(0, 0, '0, 1, 0, 22'h000010, 1, 0, 0); idle();
      enq(0, 22'h000010);
      step(0, 0, '0, 1, 0, 22'h000010, 0, 0, 1);
      res(0, 22'h000010); idle();

      enq(1, 22'h000055); enq(2, 22'h000066); enq(1, 22'h000077); res(2, 22'h000066);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_hit", hit, 0);
      chk("async_reset_redirect", redirect_valid, 0);
      chk("async_reset_full", full, 0);
      chk("async_reset_overflow", overflow, 0);
      chk("async_reset_count", mispredict_count, 0);
      for (int i = 0; i < 4; i++) mq[i].delete();
      m_ovf = 0; m_cnt = 0; sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      res(1, 22'h000055); idle();

      for (int n = 0; n < 800; n++) begin
         t = 2'($urandom_range(0, 3));
         r = 2'($urandom_range(0, 3));
         if (mq[r].size() > 0 && $urandom_range(0, 9) < 6) a = mq[r][0];
         else a = AW'(22'h000100 + $urandom_range(0, 7));
         step($urandom_range(0, 9) < 5, t, AW'(22'h000100 + $urandom_range(0, 7)),
              $urandom_range(0, 9) < 4, r, a,
              $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0);
      end
      idle(); idle();
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
